// File: rtl/dom_seq_pkg.sv
// Shared definitions for the DOM share sequencer: FSM encoding, LFSR taps,
// default seed and the bus-width derivation helpers.
package dom_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAND,
        LOAD_A,
        LOAD_B,
        WAIT,
        CAPTURE,
        CLEAR
    } seq_state_t;

    // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

    function automatic int rand_bits(input int n_shares);
        return n_shares * (n_shares - 1) / 2;
    endfunction

    function automatic int in_width(input int n_shares);
        return 2 * n_shares + rand_bits(n_shares);
    endfunction

endpackage

// File: rtl/dom_lfsr.sv
// Galois LFSR supplying all mask and fresh-random bits; steps once per enabled cycle.
module dom_lfsr
    import dom_seq_pkg::*;
#(
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/dom_share_sequencer.sv
// Splits an operand pair into Boolean shares and drives one DOM AND gate in
// staged phases. Optional result self-check built when DOM_SEQ_CHECK_EN is defined.
module dom_share_sequencer
    import dom_seq_pkg::*;
#(
    parameter int                N_SHARES  = 4,
    parameter int                N_RAND    = rand_bits(N_SHARES),
    parameter int                IN_W      = in_width(N_SHARES),
    parameter int                DOM_LAT   = 1,
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEFAULT_SEED)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_a,
    input  logic                op_b,
    output logic [IN_W-1:0]     dom_in,
    input  logic [N_SHARES-1:0] dom_out,
    output logic                res_valid,
    output logic                res,
    output logic                busy
`ifdef DOM_SEQ_CHECK_EN
    ,
    output logic                err,
    output logic [15:0]         err_cnt
`endif
);

    seq_state_t          state;
    logic [3:0]          cnt;
    logic [N_SHARES-1:0] a_sh;
    logic [N_SHARES-1:0] b_sh;
    logic [LFSR_W-1:0]   lfsr;
    logic                lfsr_unused;

    logic [N_SHARES-2:0] a_mask;
    logic [N_SHARES-2:0] b_mask;
    logic [N_SHARES-1:0] a_sh_next;
    logic [N_SHARES-1:0] b_sh_next;

`ifdef DOM_SEQ_CHECK_EN
    logic a_lat;
    logic b_lat;
`endif

    dom_lfsr #(
        .LFSR_W   (LFSR_W),
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .state(lfsr)
    );

    // Share i sits at bit i of its field; share 0 carries the operand correction.
    assign a_mask      = lfsr[N_SHARES-2:0];
    assign b_mask      = lfsr[2*N_SHARES-3:N_SHARES-1];
    assign a_sh_next   = {a_mask, op_a ^ (^a_mask)};
    assign b_sh_next   = {b_mask, op_b ^ (^b_mask)};
    assign lfsr_unused = ^lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            dom_in    <= '0;
            res_valid <= 1'b0;
            res       <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
`ifdef DOM_SEQ_CHECK_EN
            a_lat     <= 1'b0;
            b_lat     <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
`endif
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        a_sh     <= a_sh_next;
                        b_sh     <= b_sh_next;
`ifdef DOM_SEQ_CHECK_EN
                        a_lat    <= op_a;
                        b_lat    <= op_b;
`endif
                        dom_in   <= {{(2*N_SHARES){1'b0}}, lfsr[N_RAND-1:0]};
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RAND;
                    end
                end
                RAND: begin
                    dom_in[IN_W-1 -: N_SHARES] <= a_sh;
                    state                      <= LOAD_A;
                end
                LOAD_A: begin
                    dom_in[N_RAND +: N_SHARES] <= b_sh;
                    state                      <= LOAD_B;
                end
                LOAD_B: begin
                    cnt   <= 4'(DOM_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    // Sample on the edge into CAPTURE so res and res_valid line up.
                    if (cnt == 4'd0) begin
                        res       <= ^dom_out;
                        res_valid <= 1'b1;
`ifdef DOM_SEQ_CHECK_EN
                        if ((^dom_out) != (a_lat & b_lat)) begin
                            err <= 1'b1;
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                        end
`endif
                        state     <= CAPTURE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    dom_in <= '0;
                    state  <= CLEAR;
                end
                CLEAR: begin
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dom_share_sequencer.sv
// Randomized self-checking bench: three sequencers (DOM_LAT 1, 0, 15), each
// driving a behavioural DOM AND gate, checked against an operand-level model.
`timescale 1ns/1ps
module tb_dom_share_sequencer;

    localparam int N  = 4;
    localparam int NR = 6;
    localparam int W  = 14;
    localparam int NI = 3;
    localparam int LATS [NI] = '{1, 0, 15};
    localparam logic [31:0] SEED = 32'hACE1_0001;
    // Right-shift Galois mask derived from taps 32, 22, 2, 1.
    localparam logic [31:0] POLY = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic op_valid [NI];
    logic op_a     [NI];
    logic op_b     [NI];
    logic flip     [NI];
    wire  op_ready  [NI];
    wire  res_valid [NI];
    wire  res       [NI];
    wire  busy      [NI];
    wire  [W-1:0] dom_in  [NI];
    wire  [N-1:0] dom_out [NI];
`ifdef DOM_SEQ_CHECK_EN
    wire         err     [NI];
    wire  [15:0] err_cnt [NI];
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] lfsr_model [NI];

    // Product of the share vectors: XOR of all outputs equals (^a_shares) & (^b_shares).
    function automatic logic [N-1:0] gate(input logic [W-1:0] din);
        logic [N-1:0] sa;
        logic [N-1:0] sb;
        logic [N-1:0] o;
        sa = din[W-1 -: N];
        sb = din[NR +: N];
        for (int i = 0; i < N; i++) o[i] = ^(sb & {N{sa[i]}});
        return o;
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int steps);
        for (int i = 0; i < steps; i++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        return s;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic [N-1:0] now_v;
        logic [N-1:0] pipe [16];
        assign now_v = gate(dom_in[gi]) ^ {{(N-1){1'b0}}, flip[gi]};
        always_ff @(posedge clk) begin
            pipe[0] <= now_v;
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        end
        if (LATS[gi] == 0) begin : g_comb
            assign dom_out[gi] = now_v;
        end else begin : g_reg
            assign dom_out[gi] = pipe[LATS[gi]-1];
        end

        dom_share_sequencer #(.DOM_LAT(LATS[gi])) u_dut (
            .clk      (clk),
            .rst      (rst),
            .op_valid (op_valid[gi]),
            .op_ready (op_ready[gi]),
            .op_a     (op_a[gi]),
            .op_b     (op_b[gi]),
            .dom_in   (dom_in[gi]),
            .dom_out  (dom_out[gi]),
            .res_valid(res_valid[gi]),
            .res      (res[gi]),
            .busy     (busy[gi])
`ifdef DOM_SEQ_CHECK_EN
            ,
            .err      (err[gi]),
            .err_cnt  (err_cnt[gi])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on instance k; hold keeps op_valid high while busy.
    task automatic run_op(input int k, input logic a, input logic b, input bit hold, input bit fault);
        int t;
        logic [NR-1:0] rf;
        t = 0;
        while (!op_ready[k] && t < 50) begin tick(); t++; end
        check("ready_before_op", op_ready[k], 1);
        flip[k]     = fault;
        op_a[k]     = a;
        op_b[k]     = b;
        op_valid[k] = 1'b1;
        tick();
        t = 0;
        if (!hold) op_valid[k] = 1'b0;
        op_a[k] = 1'($urandom_range(0, 1));
        op_b[k] = 1'($urandom_range(0, 1));
        rf = lfsr_model[k][NR-1:0];
        check("rand_field", dom_in[k][NR-1:0], rf);
        check("rand_nonzero", dom_in[k][NR-1:0] != 0, 1);
        check("shares_zero_in_rand", dom_in[k][W-1:NR], 0);
        check("busy_in_rand", busy[k], 1);
        tick(); t++;
        check("a_shares_xor", ^dom_in[k][W-1 -: N], a);
        check("b_zero_in_load_a", dom_in[k][NR +: N], 0);
        check("rand_held", dom_in[k][NR-1:0], rf);
        tick(); t++;
        check("b_shares_xor", ^dom_in[k][NR +: N], b);
        check("a_shares_held", ^dom_in[k][W-1 -: N], a);
        while (!res_valid[k] && t < 40) begin tick(); t++; end
        check("res_latency", t, 4 + LATS[k]);
        check("res", res[k], (a & b) ^ fault);
        tick(); t++;
        check("res_valid_pulse", res_valid[k], 0);
        check("dom_in_clear", dom_in[k], 0);
        check("res_held", res[k], (a & b) ^ fault);
        while (!op_ready[k] && t < 60) begin tick(); t++; end
        check("busy_cycles", t, 6 + LATS[k]);
        op_valid[k] = 1'b0;
        flip[k]     = 1'b0;
        lfsr_model[k] = lfsr_adv(lfsr_model[k], 6 + LATS[k]);
        $display("op inst=%0d lat=%0d a=%0d b=%0d hold=%0d fault=%0d res=%0d", k, LATS[k], a, b, hold, fault, res[k]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            op_valid[k] = 1'b0;
            op_a[k] = 1'b0;
            op_b[k] = 1'b0;
            flip[k] = 1'b0;
            lfsr_model[k] = SEED;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check("reset_op_ready", op_ready[k], 1);
            check("reset_busy", busy[k], 0);
            check("reset_res_valid", res_valid[k], 0);
            check("reset_res", res[k], 0);
            check("reset_dom_in", dom_in[k], 0);
        end

        // First operation after reset, then a held-valid sweep of all operands.
        run_op(0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int ab = 0; ab < 4; ab++) run_op(0, 1'(ab >> 1), 1'(ab), 1'b1, 1'b0);

        // Reset asserted mid-operation while in LOAD_B.
        op_a[0] = 1'b1; op_b[0] = 1'b0; op_valid[0] = 1'b1;
        tick();
        op_valid[0] = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_dom_in", dom_in[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_op_ready", op_ready[0], 1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < NI; k++) lfsr_model[k] = SEED;
        run_op(0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Latency corners.
        run_op(1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(2, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(2, 1'b0, 1'b1, 1'b1, 1'b0);

        repeat (24) begin
            int k;
            k = int'($urandom_range(0, NI - 1));
            run_op(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef DOM_SEQ_CHECK_EN
        check("err_clean", err[0], 0);
        check("err_cnt_clean", err_cnt[0], 0);
        run_op(0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("err_set", err[0], 1);
        check("err_cnt_one", err_cnt[0], 1);
        run_op(0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("err_sticky", err[0], 1);
        check("err_cnt_held", err_cnt[0], 1);
        check("err_other_inst", err[1], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
